// File: rtl/inference_scheduler_pkg.sv
// rtl/inference_scheduler_pkg.sv - shared types and constants for the inference scheduler
// Package sched_pkg: FSM state encoding, image/class geometry, default timing.
// Optional feature macro used by the bundle: SCHED_PERF_CNT_EN.
package sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_ABORT = 2'd2
   } sched_state_t;

   localparam int NUM_PIXELS           = 784;
   localparam int NUM_CLASSES          = 10;
   localparam int DEF_TIMEOUT_CYCLES   = 16384;
   localparam int DEF_ABORT_RST_CYCLES = 2;

endpackage

// File: rtl/inference_scheduler_if.sv
// rtl/inference_scheduler_if.sv - handshake bundle between scheduler, loader, engine and reporter
// Signals: loader (weights_ready, img_loaded, wr_buf_sel, wr_buf_avail),
//          engine (rd_buf_sel, infer_start, infer_rst, infer_done, infer_digit),
//          reporter (result_valid, result_ready, result_digit, result_tag),
//          status (overflow_err, timeout_err), optional perf_last_latency/perf_images
//          when SCHED_PERF_CNT_EN is defined.
// Modports: master = scheduler side, slave = environment side.
interface inference_scheduler_if #(
   parameter int TAG_W = 8
);

   logic             weights_ready;
   logic             img_loaded;
   logic             wr_buf_sel;
   logic             wr_buf_avail;
   logic             rd_buf_sel;
   logic             infer_start;
   logic             infer_rst;
   logic             infer_done;
   logic [3:0]       infer_digit;
   logic             result_valid;
   logic             result_ready;
   logic [3:0]       result_digit;
   logic [TAG_W-1:0] result_tag;
   logic             overflow_err;
   logic             timeout_err;
`ifdef SCHED_PERF_CNT_EN
   logic [15:0]      perf_last_latency;
   logic [31:0]      perf_images;

   modport master (
      input  weights_ready, img_loaded, infer_done, infer_digit, result_ready,
      output wr_buf_sel, wr_buf_avail, rd_buf_sel, infer_start, infer_rst,
             result_valid, result_digit, result_tag, overflow_err, timeout_err,
             perf_last_latency, perf_images
   );

   modport slave (
      output weights_ready, img_loaded, infer_done, infer_digit, result_ready,
      input  wr_buf_sel, wr_buf_avail, rd_buf_sel, infer_start, infer_rst,
             result_valid, result_digit, result_tag, overflow_err, timeout_err,
             perf_last_latency, perf_images
   );
`else
   modport master (
      input  weights_ready, img_loaded, infer_done, infer_digit, result_ready,
      output wr_buf_sel, wr_buf_avail, rd_buf_sel, infer_start, infer_rst,
             result_valid, result_digit, result_tag, overflow_err, timeout_err
   );

   modport slave (
      output weights_ready, img_loaded, infer_done, infer_digit, result_ready,
      input  wr_buf_sel, wr_buf_avail, rd_buf_sel, infer_start, infer_rst,
             result_valid, result_digit, result_tag, overflow_err, timeout_err
   );
`endif

endinterface

// File: rtl/inference_scheduler_watchdog.sv
// rtl/inference_scheduler_watchdog.sv - clearable run counter with terminal-count flag
// Ports: clk, rst_n (async active-low), i_clear (zero the count), i_en (count up),
//        o_tc (count has reached LIMIT-1).
module sched_watchdog #(
   parameter int LIMIT = 16384
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tc
);

   localparam int CW = $clog2(LIMIT) + 1;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tc = (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/inference_scheduler.sv
// rtl/inference_scheduler.sv - ping-pong image buffer sequencer for the softmax engine
// Ports: clk, rst_n (async active-low), bus (inference_scheduler_if.master).
// Loader writes buffer wr_buf_sel while the engine reads rd_buf_sel; each full buffer
// gets one start pulse, the result lands in a one-deep tagged slot, and a watchdog
// aborts a hung run by pulsing infer_rst.
// Optional: SCHED_PERF_CNT_EN adds perf_last_latency / perf_images.
module inference_scheduler
   import sched_pkg::*;
#(
   parameter int TAG_W            = 8,
   parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
   parameter int ABORT_RST_CYCLES = DEF_ABORT_RST_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst_n,
   inference_scheduler_if.master  bus
);

   localparam int ACW = $clog2(ABORT_RST_CYCLES) + 1;

   sched_state_t           r_state;
   logic [1:0]             r_full;
   logic                   r_wr_ptr;
   logic                   r_rd_ptr;
   logic [TAG_W-1:0]       r_seq;
   logic [1:0][TAG_W-1:0]  r_tag;
   logic                   r_start;
   logic                   r_rst;
   logic                   r_res_valid;
   logic [3:0]             r_res_digit;
   logic [TAG_W-1:0]       r_res_tag;
   logic                   r_ovf;
   logic                   r_tmo;
   logic [ACW-1:0]         r_abort_cnt;
`ifdef SCHED_PERF_CNT_EN
   logic [15:0]            r_perf_cnt;
   logic [15:0]            r_perf_lat;
   logic [31:0]            r_perf_img;
`endif

   logic       w_wr_avail;
   logic       w_load;
   logic       w_start_ok;
   logic       w_done;
   logic       w_tmo;
   logic       w_wd_tc;
   logic [1:0] w_full_set;
   logic [1:0] w_full_clr;

   // Availability is the pre-edge flag, so a buffer freed this cycle cannot take a load.
   assign w_wr_avail = !r_full[r_wr_ptr];
   assign w_load     = bus.img_loaded && w_wr_avail;
   // r_res_valid is still high on a draining edge, which blocks a start that cycle.
   assign w_start_ok = r_full[r_rd_ptr] && bus.weights_ready && !r_res_valid;
   assign w_done     = (r_state == S_RUN) && bus.infer_done;
   assign w_tmo      = (r_state == S_RUN) && w_wd_tc && !bus.infer_done;
   assign w_full_set = w_load ? (2'b01 << r_wr_ptr) : 2'b00;
   assign w_full_clr = (w_done || w_tmo) ? (2'b01 << r_rd_ptr) : 2'b00;

   sched_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear ((r_state == S_IDLE) && w_start_ok),
      .i_en    (r_state == S_RUN),
      .o_tc    (w_wd_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_full      <= 2'b00;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_seq       <= '0;
         r_tag       <= '0;
         r_start     <= 1'b0;
         r_rst       <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_digit <= 4'd0;
         r_res_tag   <= '0;
         r_ovf       <= 1'b0;
         r_tmo       <= 1'b0;
         r_abort_cnt <= '0;
`ifdef SCHED_PERF_CNT_EN
         r_perf_cnt  <= 16'd0;
         r_perf_lat  <= 16'd0;
         r_perf_img  <= 32'd0;
`endif
      end else begin
         r_full <= (r_full & ~w_full_clr) | w_full_set;

         if (w_load) begin
            r_tag[r_wr_ptr] <= r_seq;
            r_seq           <= r_seq + TAG_W'(1);
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (bus.img_loaded && !w_wr_avail) begin
            r_ovf <= 1'b1;
         end
         if (r_res_valid && bus.result_ready) begin
            r_res_valid <= 1'b0;
         end

         r_start <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
         if (r_state == S_RUN && r_perf_cnt != 16'hFFFF) begin
            r_perf_cnt <= r_perf_cnt + 16'd1;
         end
`endif

         case (r_state)
            S_IDLE: begin
               if (w_start_ok) begin
                  r_start <= 1'b1;
                  r_state <= S_RUN;
`ifdef SCHED_PERF_CNT_EN
                  r_perf_cnt <= 16'd0;
`endif
               end
            end
            S_RUN: begin
               // Completion takes priority over a coincident timeout.
               if (bus.infer_done) begin
                  r_res_digit <= bus.infer_digit;
                  r_res_tag   <= r_tag[r_rd_ptr];
                  r_res_valid <= 1'b1;
                  r_rd_ptr    <= ~r_rd_ptr;
                  r_state     <= S_IDLE;
`ifdef SCHED_PERF_CNT_EN
                  r_perf_lat  <= r_perf_cnt;
                  r_perf_img  <= r_perf_img + 32'd1;
`endif
               end else if (w_wd_tc) begin
                  // The image is dropped; its tag never reaches the reporter.
                  r_tmo       <= 1'b1;
                  r_rd_ptr    <= ~r_rd_ptr;
                  r_rst       <= 1'b1;
                  r_abort_cnt <= '0;
                  r_state     <= S_ABORT;
               end
            end
            S_ABORT: begin
               if (r_abort_cnt == ACW'(ABORT_RST_CYCLES - 1)) begin
                  r_rst   <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_abort_cnt <= r_abort_cnt + ACW'(1);
               end
            end
            default: begin
               r_rst   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.wr_buf_sel   = r_wr_ptr;
   assign bus.wr_buf_avail = w_wr_avail;
   assign bus.rd_buf_sel   = r_rd_ptr;
   assign bus.infer_start  = r_start;
   assign bus.infer_rst    = r_rst;
   assign bus.result_valid = r_res_valid;
   assign bus.result_digit = r_res_digit;
   assign bus.result_tag   = r_res_tag;
   assign bus.overflow_err = r_ovf;
   assign bus.timeout_err  = r_tmo;
`ifdef SCHED_PERF_CNT_EN
   assign bus.perf_last_latency = r_perf_lat;
   assign bus.perf_images       = r_perf_img;
`endif

endmodule

// File: tb/tb_inference_scheduler.sv
// tb/tb_inference_scheduler.sv - directed self-checking bench for inference_scheduler
module tb_inference_scheduler;

   localparam int TAG_W = 8;
   localparam int TMO   = 16384;

   logic clk;
   logic rst_n;

   inference_scheduler_if #(.TAG_W(TAG_W)) bus();

   inference_scheduler #(
      .TAG_W            (TAG_W),
      .TIMEOUT_CYCLES   (TMO),
      .ABORT_RST_CYCLES (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   bit         eng_en    = 1'b1;
   int         eng_lat   = 10;
   logic [3:0] eng_digit = 4'd0;
   bit         eng_busy  = 1'b0;
   int         eng_rem   = 0;
   int         n_starts  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Engine model: done pulses eng_lat cycles after the start cycle; infer_rst kills a run.
   always @(negedge clk) begin
      bus.infer_done = 1'b0;
      if (bus.infer_rst) begin
         eng_busy = 1'b0;
      end else if (eng_busy) begin
         eng_rem = eng_rem - 1;
         if (eng_rem == 0) begin
            bus.infer_done  = 1'b1;
            bus.infer_digit = eng_digit;
            eng_busy        = 1'b0;
         end
      end
      if (bus.infer_start) begin
         n_starts = n_starts + 1;
         if (eng_en) begin
            eng_busy = 1'b1;
            eng_rem  = eng_lat;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_start(input int bound, output int cyc);
      cyc = 0;
      while (!bus.infer_start && cyc < bound) begin
         tick();
         cyc++;
      end
   endtask

   task automatic wait_result(input int bound, output int cyc);
      cyc = 0;
      while (!bus.result_valid && cyc < bound) begin
         tick();
         cyc++;
      end
   endtask

   task automatic load_image();
      bus.img_loaded = 1'b1;
      tick();
      bus.img_loaded = 1'b0;
   endtask

   task automatic accept_result();
      bus.result_ready = 1'b1;
      tick();
      bus.result_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int cyc;
      int n0;
      rst_n             = 1'b0;
      bus.weights_ready = 1'b0;
      bus.img_loaded    = 1'b0;
      bus.infer_done    = 1'b0;
      bus.infer_digit   = 4'd0;
      bus.result_ready  = 1'b0;
      tick();
      tick();

      // Reset values
      chk("rst_wr_buf_avail", bus.wr_buf_avail, 1);
      chk("rst_wr_buf_sel", bus.wr_buf_sel, 0);
      chk("rst_rd_buf_sel", bus.rd_buf_sel, 0);
      chk("rst_infer_start", bus.infer_start, 0);
      chk("rst_infer_rst", bus.infer_rst, 0);
      chk("rst_result_valid", bus.result_valid, 0);
      chk("rst_errors", {bus.overflow_err, bus.timeout_err}, 0);
      rst_n = 1'b1;
      tick();

      // T1: single image, nominal engine latency
      bus.weights_ready = 1'b1;
      eng_lat   = 7870;
      eng_digit = 4'd7;
      load_image();
      chk("t1_no_start_yet", bus.infer_start, 0);
      chk("t1_wr_sel_toggled", bus.wr_buf_sel, 1);
      chk("t1_wr_avail_buf1", bus.wr_buf_avail, 1);
      tick();
      chk("t1_start_pulse", bus.infer_start, 1);
      chk("t1_rd_sel_run", bus.rd_buf_sel, 0);
      wait_result(9000, cyc);
      chk("t1_latency", cyc, 7871);
      chk("t1_result_valid", bus.result_valid, 1);
      chk("t1_digit", bus.result_digit, 7);
      chk("t1_tag", bus.result_tag, 0);
      chk("t1_rd_sel_after", bus.rd_buf_sel, 1);
`ifdef SCHED_PERF_CNT_EN
      chk("t1_perf_images", bus.perf_images, 1);
      chk("t1_perf_latency", bus.perf_last_latency, 7870);
`endif
      accept_result();
      chk("t1_result_drained", bus.result_valid, 0);

      // T2: back-to-back loads, held result, overflow
      do_reset();
      eng_lat   = 20;
      eng_digit = 4'd5;
      n0 = n_starts;
      bus.img_loaded = 1'b1;
      tick();
      tick();
      chk("t2_both_full", bus.wr_buf_avail, 0);
      tick();
      bus.img_loaded = 1'b0;
      chk("t2_overflow", bus.overflow_err, 1);
      chk("t2_wr_sel_held", bus.wr_buf_sel, 0);
      wait_result(100, cyc);
      chk("t2_first_valid", bus.result_valid, 1);
      chk("t2_first_tag", bus.result_tag, 0);
      chk("t2_first_digit", bus.result_digit, 5);
      eng_digit = 4'd9;
      repeat (5) tick();
      chk("t2_held_valid", bus.result_valid, 1);
      chk("t2_held_tag", bus.result_tag, 0);
      chk("t2_one_start", n_starts - n0, 1);
      accept_result();
      chk("t2_drained", bus.result_valid, 0);
      chk("t2_no_start_on_drain", bus.infer_start, 0);
      tick();
      chk("t2_second_start", bus.infer_start, 1);
      wait_result(100, cyc);
      chk("t2_second_tag", bus.result_tag, 1);
      chk("t2_second_digit", bus.result_digit, 9);
      chk("t2_overflow_sticky", bus.overflow_err, 1);
      accept_result();
      chk("t2_avail_again", bus.wr_buf_avail, 1);

      // T3: hung engine, watchdog abort
      do_reset();
      eng_en = 1'b0;
      load_image();
      wait_start(10, cyc);
      chk("t3_start", bus.infer_start, 1);
      cyc = 0;
      while (!bus.timeout_err && cyc < 17000) begin
         tick();
         cyc++;
      end
      chk("t3_timeout_cycles", cyc, TMO);
      chk("t3_timeout_err", bus.timeout_err, 1);
      chk("t3_infer_rst_1", bus.infer_rst, 1);
      tick();
      chk("t3_infer_rst_2", bus.infer_rst, 1);
      tick();
      chk("t3_infer_rst_off", bus.infer_rst, 0);
      chk("t3_rd_sel_moved", bus.rd_buf_sel, 1);
      chk("t3_no_result", bus.result_valid, 0);
      eng_en    = 1'b1;
      eng_lat   = 10;
      eng_digit = 4'd4;
      load_image();
      wait_start(10, cyc);
      chk("t3_restart", bus.infer_start, 1);
      wait_result(50, cyc);
      chk("t3_next_tag", bus.result_tag, 1);
      chk("t3_next_digit", bus.result_digit, 4);
      accept_result();

      // T4: weights not ready blocks the start
      bus.weights_ready = 1'b0;
      eng_lat = 50;
      n0 = n_starts;
      load_image();
      repeat (5) tick();
      chk("t4_blocked", n_starts - n0, 0);
      bus.weights_ready = 1'b1;
      tick();
      chk("t4_start_after_ready", bus.infer_start, 1);

      // T5: asynchronous reset mid-run
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_avail", bus.wr_buf_avail, 1);
      chk("t5_outputs_zero", {bus.infer_start, bus.infer_rst, bus.result_valid,
                              bus.rd_buf_sel, bus.wr_buf_sel}, 0);
      chk("t5_errors_cleared", {bus.overflow_err, bus.timeout_err}, 0);
      tick();
      rst_n = 1'b1;
      repeat (80) tick();
      chk("t5_no_stale_result", bus.result_valid, 0);
      chk("t5_no_restart", n_starts - n0, 1);

`ifdef SCHED_PERF_CNT_EN
      // T6: performance counters over two runs
      do_reset();
      chk("t6_perf_rst", {bus.perf_last_latency, bus.perf_images[15:0]}, 0);
      eng_lat = 7870;
      load_image();
      wait_result(9000, cyc);
      accept_result();
      eng_lat = 100;
      load_image();
      wait_result(200, cyc);
      accept_result();
      chk("t6_perf_images", bus.perf_images, 2);
      chk("t6_perf_latency", bus.perf_last_latency, 100);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/inference_scheduler.md
Name: inference_scheduler

Overview:
- Sequences the softmax inference engine over a ping-pong pair of 784-byte image buffers.
- The image loader fills one buffer while the engine reads the other. The scheduler issues start pulses and captures the predicted digit into a one-deep tagged result slot for the UART reporter.
- A watchdog recovers the engine through its reset if a start never completes.

Parameters:
TAG_W, 8, width of the per-image sequence tag (wraps modulo 2^TAG_W)
TIMEOUT_CYCLES, 16384, cycles from start pulse to inference_done before abort (nominal run ~7870)
ABORT_RST_CYCLES, 2, length of the engine reset pulse on abort

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
weights_ready  in  1  weights/biases loaded
img_loaded  in  1  pulse: loader finished writing buffer wr_buf_sel
wr_buf_sel  out  1  buffer the loader must write (image RAM address MSB)
wr_buf_avail  out  1  buffer wr_buf_sel is free
rd_buf_sel  out  1  buffer the engine reads (image RAM address MSB)
infer_start  out  1  one-cycle start pulse to engine
infer_rst  out  1  engine reset (active-high), asserted only on abort
infer_done  in  1  engine completion pulse
infer_digit  in  4  engine predicted_digit, valid in the infer_done cycle
result_valid  out  1  result slot occupied
result_ready  in  1  consumer accepts result
result_digit  out  4  captured digit
result_tag  out  TAG_W  sequence tag of that image
overflow_err  out  1  sticky: img_loaded while !wr_buf_avail
timeout_err  out  1  sticky: watchdog fired

Behaviour:
- Reset (async, rst_n low): all outputs 0 except wr_buf_avail=1. Buffer full flags = 00, wr_ptr = rd_ptr = 0, seq counter = 0, state = S_IDLE, watchdog = 0.
- Reset mid-run drops both buffers' contents and any pending result.
- Write side:
  - wr_buf_sel = wr_ptr; wr_buf_avail = !full[wr_ptr].
  - img_loaded with avail: full[wr_ptr]<=1, tag[wr_ptr]<=seq, seq<=seq+1, wr_ptr toggles.
  - img_loaded without avail: ignored, overflow_err<=1, seq unchanged.
  - Avail is the pre-edge value. A buffer freed in the same cycle does not accept that load.
- rd_buf_sel = rd_ptr, constant for the whole run.
- FSM:
  - S_IDLE: when full[rd_ptr] && weights_ready && !result_valid: infer_start<=1 for one cycle, clear watchdog, go S_RUN. Priority: a result draining in the same cycle (result_valid && result_ready) does not permit a start that cycle.
  - S_RUN: watchdog increments each cycle.
    - infer_done: result_digit<=infer_digit, result_tag<=tag[rd_ptr], result_valid<=1, full[rd_ptr]<=0, rd_ptr toggles, go S_IDLE.
    - Watchdog == TIMEOUT_CYCLES-1 without done: timeout_err<=1, full[rd_ptr]<=0, rd_ptr toggles (image dropped, seq gap visible downstream), go S_ABORT.
    - Done and timeout in the same cycle: done wins.
  - S_ABORT: infer_rst=1 for ABORT_RST_CYCLES cycles, then S_IDLE.
  - infer_done outside S_RUN is ignored.
- weights_ready falling during S_RUN does not stop the run; it only blocks new starts.
- Result slot: result_valid && result_ready clears result_valid next edge. Digit and tag are held stable while valid.
- Throughput: at most one start per image. Start-to-result latency = engine latency + 1 cycle.
- Sticky errors clear only on reset.

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- When defined, adds outputs perf_last_latency[15:0] and perf_images[31:0].
  - perf_last_latency: cycles from start pulse to done of the last completed run; saturates at 0xFFFF.
  - perf_images: count of completed results, wraps.
  - Both reset to 0 and are not updated by aborts.
- When undefined, these ports and their counters are absent. All other behaviour is identical.

Decomposition:
- Shared package sched_pkg: state encoding (S_IDLE, S_RUN, S_ABORT), NUM_PIXELS=784, NUM_CLASSES=10, default TIMEOUT_CYCLES.
- One sub-module, sched_watchdog: clearable counter with terminal-count flag.
- Buffer/pointer logic and the FSM stay in the top.

Test Plan:
- weights_ready=1; img_loaded on buffer 0; model engine done with digit 7 after 7870 cycles -> infer_start one cycle after load, result_valid, digit 7, tag 0, rd_buf_sel toggles to 1.
- Two back-to-back loads with result_ready=0 -> second run waits until the first result is accepted; third img_loaded with both full -> ignored, overflow_err=1, tags 0,1 delivered in order.
- Engine never asserts done -> after 16384 cycles timeout_err=1, infer_rst high exactly 2 cycles, buffer freed, next image's result carries tag 1.
- weights_ready=0 with full buffer -> no infer_start; raise weights_ready -> start next cycle.
- rst_n pulsed low mid-S_RUN -> outputs immediately at reset values, wr_buf_avail=1, no stale result afterwards.
- SCHED_PERF_CNT_EN: two runs of 7870 and 100 cycles -> perf_images=2, perf_last_latency=100.
